// File: rtl/ghost_chase_ai.sv
// Autonomous ghost steering: periodically scores the four neighbouring tiles against
// a scatter corner or the player's tile and holds the winner on active-low w/a/s/d.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef TILE_SIZE
`define TILE_SIZE 20
`endif
`ifndef TILE_COL_NUM
`define TILE_COL_NUM 32
`endif
`ifndef TILE_ROW_NUM
`define TILE_ROW_NUM 24
`endif
`ifndef WIDTH_LOG2
`define WIDTH_LOG2 10
`endif
`ifndef DIR_UP
`define DIR_UP 2'd0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 2'd1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

// state      | meaning
// S_IDLE     | waiting for decision-counter terminal count
// S_UP       | score up probe (target and ghost position latched on entry)
// S_LEFT     | score left probe
// S_DOWN     | score down probe
// S_RIGHT    | score right probe
// S_COMMIT   | drive winner (or dead-end reverse) onto request lines
module ghost_chase_ai #(
    parameter int DECIDE_PERIOD     = 20,
    parameter int PROBE             = 20,
    parameter int SCATTER_TX        = 0,
    parameter int SCATTER_TY        = 0,
    parameter int SCATTER_DECISIONS = 7,
    parameter int CHASE_DECISIONS   = 20,
    parameter int BOUNDARY_X0       = 0,
    parameter int BOUNDARY_X1       = 620,
    parameter int BOUNDARY_Y0       = 0,
    parameter int BOUNDARY_Y1       = 460
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       enable,
    input  logic [`WIDTH_LOG2-1:0]                     x,
    input  logic [$clog2(`HEIGHT)-1:0]                 y,
    input  logic [`WIDTH_LOG2-1:0]                     player_x,
    input  logic [`WIDTH_LOG2-1:0]                     player_y,
    input  logic [`TILE_ROW_NUM*`TILE_COL_NUM-1:0]     tilemap_walls,
    output logic                                       w,
    output logic                                       a,
    output logic                                       s,
    output logic                                       d,
    output logic [1:0]                                 ghost_direction,
    output logic                                       chase_mode
);

    localparam int XW     = `WIDTH_LOG2;
    localparam int YW     = $clog2(`HEIGHT);
    localparam int PW     = XW + 2;
    localparam int TW     = 6;
    localparam int NT     = `TILE_ROW_NUM * `TILE_COL_NUM;
    localparam int IW     = $clog2(NT);
    localparam int CW     = $clog2(DECIDE_PERIOD);
    localparam int MC_MAX = (CHASE_DECISIONS > SCATTER_DECISIONS) ? CHASE_DECISIONS : SCATTER_DECISIONS;
    localparam int MW     = $clog2(MC_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UP     = 3'd1;
    localparam logic [2:0] S_LEFT   = 3'd2;
    localparam logic [2:0] S_DOWN   = 3'd3;
    localparam logic [2:0] S_RIGHT  = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] lx_q, lx_d;
    logic [YW-1:0] ly_q, ly_d;
    logic [TW-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [6:0]    best_q, best_d;
    logic          found_q, found_d;
    logic [1:0]    best_dir_q, best_dir_d;
    logic [3:0]    raw_ok_q, raw_ok_d;
    logic [3:0]    req_q, req_d;
    logic [1:0]    dir_q, dir_d;
    logic          chase_q, chase_d;
    logic [MW-1:0] mode_cnt_q, mode_cnt_d;

    logic [1:0]    cand_dir, rev_dir;
    logic [PW-1:0] px, py;
    logic          under, in_b, wall, ok, elig;
    logic [TW-1:0] pcol, prow;
    logic [IW-1:0] widx;
    logic [6:0]    score;
    logic [MW-1:0] mode_inc;
    logic          tc;

    function automatic logic [TW-1:0] absdiff(input logic [TW-1:0] p, input logic [TW-1:0] q);
        return (p >= q) ? p - q : q - p;
    endfunction

    assign rev_dir = {dir_q[1], ~dir_q[0]};

    always_comb begin
        cand_dir = `DIR_UP;
        case (state_q)
            S_LEFT:  cand_dir = `DIR_LEFT;
            S_DOWN:  cand_dir = `DIR_DOWN;
            S_RIGHT: cand_dir = `DIR_RIGHT;
            default: cand_dir = `DIR_UP;
        endcase
    end

    // One shared probe datapath, steered by the state's candidate direction.
    always_comb begin
        px    = PW'(lx_q);
        py    = PW'(ly_q);
        under = 1'b0;
        case (cand_dir)
            `DIR_UP: begin
                under = PW'(ly_q) < PW'(PROBE);
                py    = PW'(ly_q) - PW'(PROBE);
            end
            `DIR_LEFT: begin
                under = PW'(lx_q) < PW'(PROBE);
                px    = PW'(lx_q) - PW'(PROBE);
            end
            `DIR_DOWN:  py = PW'(ly_q) + PW'(PROBE);
            default:    px = PW'(lx_q) + PW'(PROBE);
        endcase
        in_b  = (int'(px) >= BOUNDARY_X0) && (int'(px) <= BOUNDARY_X1) &&
                (int'(py) >= BOUNDARY_Y0) && (int'(py) <= BOUNDARY_Y1);
        pcol  = TW'(px / PW'(`TILE_SIZE));
        prow  = TW'(py / PW'(`TILE_SIZE));
        widx  = IW'(int'(prow) * (`WIDTH / `TILE_SIZE) + int'(pcol));
        wall  = in_b ? tilemap_walls[widx] : 1'b0;
        ok    = !under && in_b && !wall;
        elig  = ok && (cand_dir != rev_dir);
        score = 7'(absdiff(pcol, tx_q)) + 7'(absdiff(prow, ty_q));
    end

    always_comb begin
        state_d    = state_q;
        lx_d       = lx_q;
        ly_d       = ly_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        best_d     = best_q;
        found_d    = found_q;
        best_dir_d = best_dir_q;
        raw_ok_d   = raw_ok_q;
        req_d      = req_q;
        dir_d      = dir_q;
        chase_d    = chase_q;
        mode_cnt_d = mode_cnt_q;
        mode_inc   = mode_cnt_q + 1'b1;
        tc         = (cnt_q == CW'(DECIDE_PERIOD - 1));
        cnt_d      = tc ? '0 : cnt_q + 1'b1;

        if (!enable) begin
            state_d = S_IDLE;
            req_d   = 4'b1111;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tc) begin
                        state_d  = S_UP;
                        lx_d     = x;
                        ly_d     = y;
                        found_d  = 1'b0;
                        best_d   = 7'h7f;
                        raw_ok_d = 4'b0000;
                        if (chase_q) begin
                            tx_d = TW'(player_x / XW'(`TILE_SIZE));
                            ty_d = TW'(player_y / XW'(`TILE_SIZE));
                        end else begin
                            tx_d = TW'(SCATTER_TX);
                            ty_d = TW'(SCATTER_TY);
                        end
                    end
                end
                S_UP, S_LEFT, S_DOWN, S_RIGHT: begin
                    raw_ok_d[cand_dir] = ok;
                    // Strictly-lower replacement gives the up > left > down > right tie order.
                    if (elig && (!found_q || score < best_q)) begin
                        found_d    = 1'b1;
                        best_d     = score;
                        best_dir_d = cand_dir;
                    end
                    state_d = state_q + 3'd1;
                end
                S_COMMIT: begin
                    state_d = S_IDLE;
                    if (found_q) begin
                        req_d = ~(4'b0001 << best_dir_q);
                        dir_d = best_dir_q;
                    end else if (raw_ok_q[rev_dir]) begin
                        req_d = ~(4'b0001 << rev_dir);
                        dir_d = rev_dir;
                    end else begin
                        req_d = 4'b1111;
                    end
                    if (mode_inc == (chase_q ? MW'(CHASE_DECISIONS) : MW'(SCATTER_DECISIONS))) begin
                        chase_d    = ~chase_q;
                        mode_cnt_d = '0;
                    end else begin
                        mode_cnt_d = mode_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lx_q       <= '0;
            ly_q       <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            best_q     <= 7'h7f;
            found_q    <= 1'b0;
            best_dir_q <= `DIR_UP;
            raw_ok_q   <= 4'b0000;
            req_q      <= 4'b1111;
            dir_q      <= `DIR_LEFT;
            chase_q    <= 1'b0;
            mode_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lx_q       <= lx_d;
            ly_q       <= ly_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            best_q     <= best_d;
            found_q    <= found_d;
            best_dir_q <= best_dir_d;
            raw_ok_q   <= raw_ok_d;
            req_q      <= req_d;
            dir_q      <= dir_d;
            chase_q    <= chase_d;
            mode_cnt_q <= mode_cnt_d;
        end
    end

    assign w               = req_q[`DIR_UP];
    assign a               = req_q[`DIR_LEFT];
    assign s               = req_q[`DIR_DOWN];
    assign d               = req_q[`DIR_RIGHT];
    assign ghost_direction = dir_q;
    assign chase_mode      = chase_q;

endmodule

// File: doc/ghost_chase_ai.md
Name: ghost_chase_ai

Overview:
- Autonomous direction generator for one ghost. It drives the same active-low w/a/s/d request lines a ghost movement controller samples, replacing the pushbuttons.
- Periodically evaluates the four neighbouring tiles against the wall map and a target tile. The target is a fixed scatter corner or the player's tile, depending on mode.
- The chosen direction is held on the request lines until the next decision.
- Sits between the player/tilemap state and the ghost movement controller. It reads that controller's x/y.

Parameters:
- DECIDE_PERIOD, 20, clocks between decision starts; must be ≥ 6.
- PROBE, 20, pixel offset of each probe point from the ghost position (one tile).
- SCATTER_TX, 0, scatter target tile column.
- SCATTER_TY, 0, scatter target tile row.
- SCATTER_DECISIONS, 7, number of decisions spent in scatter mode before switching to chase.
- CHASE_DECISIONS, 20, number of decisions spent in chase mode before switching to scatter.
- boundary_x0 / boundary_x1 / boundary_y0 / boundary_y1, 0 / 620 / 0 / 460, legal pixel range for probe points.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = generate requests; 0 = release all requests.
- x  in  `width_log2  ghost pixel x.
- y  in  $clog2(`HEIGHT)  ghost pixel y.
- player_x  in  `width_log2  player pixel x.
- player_y  in  `width_log2  player pixel y.
- tilemap_walls  in  `tile_row_num*`tile_col_num  1 = wall. Index = (`WIDTH/`tile_size)*row + col.
- w, a, s, d  out  1 each  active-low up/left/down/right requests. At most one is low at any time.
- ghost_direction  out  2  last committed direction, using `dir_up/`dir_down/`dir_left/`dir_right.
- chase_mode  out  1  1 = chase (target is the player tile), 0 = scatter.

Behaviour:
- Reset, sampled on the clk edge while reset=0:
  - w=a=s=d=1; ghost_direction=`dir_left; chase_mode=0.
  - Decision counter=0; mode decision count=0; FSM=IDLE.
  - Applies from any state, including mid-EVAL.
- Decision counter:
  - Free-runs 0..DECIDE_PERIOD-1 and wraps.
  - Terminal count (DECIDE_PERIOD-1) with enable=1 and FSM=IDLE moves the FSM to EVAL_UP.
- FSM: IDLE → EVAL_UP → EVAL_LEFT → EVAL_DOWN → EVAL_RIGHT → COMMIT → IDLE, one cycle per state.
  - Outputs change on the COMMIT edge, 5 clocks after the terminal-count edge.
- Target latch, on entry to EVAL_UP:
  - Chase: (player_x/`tile_size, player_y/`tile_size).
  - Scatter: (SCATTER_TX, SCATTER_TY).
  - x and y are also latched here, so mid-evaluation motion is ignored.
- Probe points, computed from the latched x/y:
  - Up: (x, y−PROBE). Left: (x−PROBE, y). Down: (x, y+PROBE). Right: (x+PROBE, y).
  - Subtraction underflow (operand < PROBE) makes the candidate invalid.
  - A probe outside [boundary_x0,boundary_x1] × [boundary_y0,boundary_y1] is invalid.
  - A wall bit of 1 at the probe tile makes the candidate invalid.
  - The exact reverse of ghost_direction is excluded.
- Score = |probe_col − target_col| + |probe_row − target_row|, unsigned, 7 bits.
  - The best (lowest) score is kept in a register.
  - A candidate replaces the best only if its score is strictly lower, so ties resolve in the order up > left > down > right.
- COMMIT:
  - If any candidate is valid: the winner's line goes low, the other three go high, and ghost_direction takes the winner.
  - If none is valid (dead end): the reverse is chosen if its probe is valid (wall-free, in bounds). Otherwise all four lines go high and ghost_direction is unchanged.
  - The mode decision count then increments. On reaching SCATTER_DECISIONS (scatter) or CHASE_DECISIONS (chase), chase_mode toggles and the count clears.
  - SCATTER_DECISIONS=0 has no special meaning and must not be used; the minimum is 1.
- enable=0:
  - w=a=s=d=1 on the next edge; FSM forced to IDLE (an in-flight evaluation is discarded).
  - ghost_direction, chase_mode, the mode count and the decision counter are retained; the counter keeps running.
  - After enable returns to 1, the next terminal count starts an evaluation.
- Requests stay stable between COMMITs. The w/a/s/d lines never glitch through two-low states.

Test Plan:
- Open map, ghost (100,100), scatter target (0,0), reset dir `dir_left → right excluded; up and left both score 9. After first terminal count +5 clk: w=0, a=s=d=1, ghost_direction=`dir_up.
- Same as scenario 1 plus wall at tile (col 5, row 4) → a=0, ghost_direction=`dir_left.
- Walls at tiles (5,4), (4,5), (5,6), dir `dir_left → dead end, reverse (6,5) open → d=0, ghost_direction=`dir_right. Then add wall (6,5) → all lines 1, direction unchanged.
- SCATTER_DECISIONS=1, player (300,100), open map, ghost (100,100):
  - Decision 1 → w=0 and chase_mode becomes 1.
  - Decision 2 targets tile (15,5); down excluded; up 11, left 11, right 9 → d=0.
- Drop enable during EVAL_DOWN → next clk all lines 1, no COMMIT. Raise enable → output appears exactly terminal count +5 clk.
- Assert reset during EVAL_LEFT for one clk → next clk w=a=s=d=1, ghost_direction=`dir_left, chase_mode=0, counter restarts at 0.
- Ghost at x=10 with dir `dir_right → left probe underflows → invalid, never chosen.
